// File: rtl/ga_pkg.sv
// ga_pkg: shared widths, counter constants and sequencer state encoding for the fitness evaluator.
package ga_pkg;
    localparam int NUM_PARTICLE_TYPE = 3;
    localparam int DATA_WIDTH = 4;
    localparam int LATTICE_LENGTH = 11;
    localparam int PARTICLE_LENGTH = 2;
    localparam int SELF_FIT_LENGTH = 10;
    localparam int POP_SIZE = 50;
    localparam int ADDR_W = $clog2(POP_SIZE);
    localparam int CNT_W = ADDR_W + 1;
    localparam int IND_W = LATTICE_LENGTH * PARTICLE_LENGTH;
    localparam int SE_W = NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam int IM_W = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam logic [CNT_W-1:0] POP_CNT = CNT_W'(POP_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POP_SIZE - 1);

    typedef enum logic [2:0] {IDLE, CFG, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/min_tracker.sv
// min_tracker: running minimum energy and its index, committed to the visible result once per pass.
module min_tracker
    import ga_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       update,
    input  logic                       commit,
    input  logic [SELF_FIT_LENGTH-1:0] energy,
    input  logic [ADDR_W-1:0]          idx,
    output logic [SELF_FIT_LENGTH-1:0] best_energy,
    output logic [ADDR_W-1:0]          best_idx
);
    logic [SELF_FIT_LENGTH-1:0] run_energy;
    logic [ADDR_W-1:0]          run_idx;

    // strict less-than keeps the earliest index on ties
    always_ff @(posedge clk) begin
        if (rst) begin
            run_energy  <= '1;
            run_idx     <= '0;
            best_energy <= '1;
            best_idx    <= '0;
        end else begin
            if (clear) begin
                run_energy <= '1;
                run_idx    <= '0;
            end else if (update && energy < run_energy) begin
                run_energy <= energy;
                run_idx    <= idx;
            end
            if (commit) begin
                best_energy <= run_energy;
                best_idx    <= run_idx;
            end
        end
    end
endmodule

// File: rtl/fitness_eval_ctrl.sv
// fitness_eval_ctrl: streams one population bank through the fitness evaluator, stores energies and tracks the best.
module fitness_eval_ctrl
    import ga_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       pop_sel_i,
    input  logic [SE_W-1:0]            self_energy_vec_i,
    input  logic [IM_W-1:0]            interact_matrix_i,
    output logic                       pop_rd_en_o,
    output logic [ADDR_W-1:0]          pop_rd_addr_o,
    input  logic [IND_W-1:0]           pop_rd_data_i,
    output logic                       ev_set_data_o,
    output logic [SE_W-1:0]            ev_self_energy_o,
    output logic [IM_W-1:0]            ev_interact_o,
    output logic                       ev_in_valid_o,
    output logic [IND_W-1:0]           ev_ind_vec_o,
    output logic                       ev_ind_idx_o,
    input  logic                       ev_out_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0] ev_energy_i,
    input  logic                       ev_wb_idx_i,
    output logic                       fit_wr_en_o,
    output logic [ADDR_W:0]            fit_wr_addr_o,
    output logic [SELF_FIT_LENGTH-1:0] fit_wr_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [SELF_FIT_LENGTH-1:0] best_energy_o,
    output logic [ADDR_W-1:0]          best_idx_o,
    output logic                       err_o
);
    state_t           state, state_nx;
    logic             bank;
    logic [SE_W-1:0]  se_q;
    logic [IM_W-1:0]  im_q;
    logic [CNT_W-1:0] iss_cnt, wb_cnt;
    logic             in_valid_q, err_q;
    logic             accept, result_ok, bad_result;

    assign accept = state == IDLE && start_i;
    // results only count while a pass is collecting and not yet full
    assign result_ok = ev_out_valid_i && (state == ISSUE || state == DRAIN) && wb_cnt < POP_CNT;
    assign bad_result = ev_out_valid_i &&
        (ev_wb_idx_i != bank || state == IDLE || state == CFG || wb_cnt == POP_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? (start_i ? CFG : IDLE) :
                   state == CFG   ? ISSUE :
                   state == ISSUE ? (iss_cnt == LAST_CNT ? DRAIN : ISSUE) :
                   state == DRAIN ? (wb_cnt == POP_CNT ? DONE : DRAIN) : IDLE;
    end

    always_comb begin
        pop_rd_en_o      = state == ISSUE;
        pop_rd_addr_o    = iss_cnt[ADDR_W-1:0];
        ev_set_data_o    = state == CFG;
        ev_self_energy_o = se_q;
        ev_interact_o    = im_q;
        ev_in_valid_o    = in_valid_q;
        ev_ind_vec_o     = in_valid_q ? pop_rd_data_i : '0;
        ev_ind_idx_o     = bank;
        fit_wr_en_o      = result_ok;
        fit_wr_addr_o    = result_ok ? {ev_wb_idx_i, wb_cnt[ADDR_W-1:0]} : '0;
        fit_wr_data_o    = result_ok ? ev_energy_i : '0;
        busy_o           = state != IDLE;
        done_o           = state == DONE;
        err_o            = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank       <= 1'b0;
            se_q       <= '0;
            im_q       <= '0;
            iss_cnt    <= '0;
            wb_cnt     <= '0;
            in_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                bank <= pop_sel_i;
                se_q <= self_energy_vec_i;
                im_q <= interact_matrix_i;
            end
            // RAM data lands one cycle after the read strobe
            in_valid_q <= state == ISSUE;
            iss_cnt    <= state == CFG ? '0 : state == ISSUE ? iss_cnt + 1'b1 : iss_cnt;
            wb_cnt     <= state == CFG ? '0 : result_ok ? wb_cnt + 1'b1 : wb_cnt;
            err_q      <= (accept ? 1'b0 : err_q) | bad_result;
        end
    end

    min_tracker u_min (
        .clk         (clk_i),
        .rst         (rst_i),
        .clear       (state == CFG),
        .update      (result_ok),
        .commit      (state == DONE),
        .energy      (ev_energy_i),
        .idx         (wb_cnt[ADDR_W-1:0]),
        .best_energy (best_energy_o),
        .best_idx    (best_idx_o)
    );
endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// tb_fitness_eval_ctrl: table-driven passes against a RAM/evaluator model and a reference energy scoreboard.
module tb_fitness_eval_ctrl;
    import ga_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_i = 1'b1, start_i = 1'b0, pop_sel_i = 1'b0;
    logic [SE_W-1:0]            self_energy_vec_i = '0;
    logic [IM_W-1:0]            interact_matrix_i = '0;
    logic                       pop_rd_en_o;
    logic [ADDR_W-1:0]          pop_rd_addr_o;
    logic [IND_W-1:0]           pop_rd_data_i = '0;
    logic                       ev_set_data_o;
    logic [SE_W-1:0]            ev_self_energy_o;
    logic [IM_W-1:0]            ev_interact_o;
    logic                       ev_in_valid_o;
    logic [IND_W-1:0]           ev_ind_vec_o;
    logic                       ev_ind_idx_o;
    logic                       ev_out_valid_i = 1'b0;
    logic [SELF_FIT_LENGTH-1:0] ev_energy_i = '0;
    logic                       ev_wb_idx_i = 1'b0;
    logic                       fit_wr_en_o;
    logic [ADDR_W:0]            fit_wr_addr_o;
    logic [SELF_FIT_LENGTH-1:0] fit_wr_data_o;
    logic                       busy_o, done_o, err_o;
    logic [SELF_FIT_LENGTH-1:0] best_energy_o;
    logic [ADDR_W-1:0]          best_idx_o;

    always #5 clk = ~clk;

    fitness_eval_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pop_sel_i(pop_sel_i),
        .self_energy_vec_i(self_energy_vec_i), .interact_matrix_i(interact_matrix_i),
        .pop_rd_en_o(pop_rd_en_o), .pop_rd_addr_o(pop_rd_addr_o), .pop_rd_data_i(pop_rd_data_i),
        .ev_set_data_o(ev_set_data_o), .ev_self_energy_o(ev_self_energy_o), .ev_interact_o(ev_interact_o),
        .ev_in_valid_o(ev_in_valid_o), .ev_ind_vec_o(ev_ind_vec_o), .ev_ind_idx_o(ev_ind_idx_o),
        .ev_out_valid_i(ev_out_valid_i), .ev_energy_i(ev_energy_i), .ev_wb_idx_i(ev_wb_idx_i),
        .fit_wr_en_o(fit_wr_en_o), .fit_wr_addr_o(fit_wr_addr_o), .fit_wr_data_o(fit_wr_data_o),
        .busy_o(busy_o), .done_o(done_o), .best_energy_o(best_energy_o), .best_idx_o(best_idx_o),
        .err_o(err_o)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // energy as defined by the physics: self terms per site plus both directions of each neighbour pair;
    // mode 1 is a test evaluator that returns the low bits of the individual verbatim
    function automatic logic [SELF_FIT_LENGTH-1:0] energy_of(logic [IND_W-1:0] v, logic [SE_W-1:0] se,
                                                             logic [IM_W-1:0] im, int mode);
        int e = 0;
        int a, b;
        if (mode == 1) return v[SELF_FIT_LENGTH-1:0];
        for (int i = 0; i < LATTICE_LENGTH; i++) begin
            a = int'(v[2*i +: 2]);
            e += int'(se[a*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int i = 0; i < LATTICE_LENGTH - 1; i++) begin
            a = int'(v[2*i +: 2]);
            b = int'(v[2*i+2 +: 2]);
            e += int'(im[(a*3+b)*DATA_WIDTH +: DATA_WIDTH]) + int'(im[(b*3+a)*DATA_WIDTH +: DATA_WIDTH]);
        end
        return SELF_FIT_LENGTH'(e);
    endfunction

    logic [IND_W-1:0]           mem [POP_SIZE];
    int                         mlat = 4, mmode = 0, mbad = -1, outn = 0;
    logic [SE_W-1:0]            m_se = '0;
    logic [IM_W-1:0]            m_im = '0;
    logic                       vp [8];
    logic [SELF_FIT_LENGTH-1:0] ep [8];
    logic                       tp [8];

    // population RAM (1-cycle read) and a fixed-latency evaluator pipe, updated just after each edge
    always @(posedge clk) begin
        #1;
        if (rst_i) begin
            for (int j = 0; j < 8; j++) begin
                vp[j] = 1'b0; ep[j] = '0; tp[j] = 1'b0;
            end
            ev_out_valid_i = 1'b0; ev_energy_i = '0; ev_wb_idx_i = 1'b0; pop_rd_data_i = '0;
        end else begin
            if (ev_set_data_o) begin
                m_se = ev_self_energy_o; m_im = ev_interact_o; outn = 0;
            end
            for (int j = 7; j > 0; j--) begin
                vp[j] = vp[j-1]; ep[j] = ep[j-1]; tp[j] = tp[j-1];
            end
            vp[0] = ev_in_valid_o;
            ep[0] = energy_of(ev_ind_vec_o, m_se, m_im, mmode);
            tp[0] = ev_ind_idx_o;
            ev_out_valid_i = vp[mlat-1];
            ev_energy_i = vp[mlat-1] ? ep[mlat-1] : '0;
            ev_wb_idx_i = vp[mlat-1] ? tp[mlat-1] ^ (outn == mbad) : 1'b0;
            if (vp[mlat-1]) outn++;
            if (pop_rd_en_o) pop_rd_data_i = mem[pop_rd_addr_o];
        end
    end

    logic [ADDR_W+SELF_FIT_LENGTH:0] wq[$], saved_q[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (fit_wr_en_o) wq.push_back({fit_wr_addr_o, fit_wr_data_o});
        if (done_o) done_cnt++;
    end

    typedef struct {
        int                         pat;
        logic                       sel;
        int                         lat;
        int                         bad;
        logic                       use_const;
        logic [SELF_FIT_LENGTH-1:0] exp_e;
        int                         exp_i;
    } vec_t;

    logic [SE_W-1:0] tse;
    logic [IM_W-1:0] tim;
    int              cur_mode = 0;

    task automatic run_pass(input vec_t r, input string tag, output int lat);
        logic [SELF_FIT_LENGTH-1:0] ee [POP_SIZE];
        logic [SELF_FIT_LENGTH-1:0] be;
        int bi;
        logic [IND_W-1:0] v;
        if (r.pat != 4) begin
            tse = SE_W'($urandom); tim = IM_W'({$urandom, $urandom});
            cur_mode = (r.pat == 1 || r.pat == 3) ? 1 : 0;
        end
        for (int i = 0; i < POP_SIZE; i++) begin
            if (r.pat == 0) mem[i] = '0;
            if (r.pat == 1) mem[i] = (i == 23 || i == 40) ? IND_W'(7) : IND_W'(10 + i);
            if (r.pat == 3) mem[i] = IND_W'($urandom);
            if (r.pat == 2) begin
                v = '0;
                for (int s = 0; s < LATTICE_LENGTH; s++) v[2*s +: 2] = 2'($urandom_range(0, 2));
                mem[i] = v;
            end
        end
        if (r.pat == 0) begin
            tse = {4'd3, 4'd2, 4'd1}; tim = {9{4'd1}};
        end
        be = '1; bi = 0;
        for (int i = 0; i < POP_SIZE; i++) begin
            ee[i] = energy_of(mem[i], tse, tim, cur_mode);
            if (ee[i] < be) begin be = ee[i]; bi = i; end
        end
        @(negedge clk);
        wq.delete(); done_cnt = 0;
        mlat = r.lat; mbad = r.bad; mmode = cur_mode;
        start_i = 1'b1; pop_sel_i = r.sel; self_energy_vec_i = tse; interact_matrix_i = tim;
        @(negedge clk);
        start_i = 1'b0; pop_sel_i = ~r.sel;
        self_energy_vec_i = SE_W'($urandom); interact_matrix_i = IM_W'({$urandom, $urandom});
        lat = 1;
        while (!done_o && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done_seen"}, done_o, 1);
        repeat (4) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_after"}, busy_o, 0);
        chk({tag, "_err"}, err_o, r.bad >= 0);
        chk({tag, "_wr_count"}, wq.size(), POP_SIZE);
        for (int i = 0; i < POP_SIZE && i < wq.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), wq[i], {r.sel ^ (i == r.bad), ADDR_W'(i), ee[i]});
        chk({tag, "_best_e"}, best_energy_o, be);
        chk({tag, "_best_i"}, best_idx_o, bi);
        if (r.use_const) begin
            chk({tag, "_best_e_const"}, best_energy_o, r.exp_e);
            chk({tag, "_best_i_const"}, best_idx_o, r.exp_i);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[6];
        int lat[6];
        int n, strobes, diff;
        vec_t fresh;
        tbl[0] = '{0, 1'b0, 4, -1, 1'b1, 10'd31, 0};
        tbl[1] = '{1, 1'b0, 5, -1, 1'b1, 10'd7, 23};
        tbl[2] = '{2, 1'b1, 3, -1, 1'b0, 10'd0, 0};
        tbl[3] = '{3, 1'b1, 6, 17, 1'b0, 10'd0, 0};
        tbl[4] = '{3, 1'b0, 4, -1, 1'b0, 10'd0, 0};
        tbl[5] = '{4, 1'b0, 7, -1, 1'b0, 10'd0, 0};

        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd_en", pop_rd_en_o, 0);
        chk("rst_wr_en", fit_wr_en_o, 0);
        chk("rst_set_data", ev_set_data_o, 0);
        chk("rst_in_valid", ev_in_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_best_e", best_energy_o, 10'h3FF);
        chk("rst_best_i", best_idx_o, 0);

        for (int k = 0; k < 6; k++) begin
            run_pass(tbl[k], $sformatf("row%0d", k), lat[k]);
            if (k == 3) begin
                repeat (3) @(negedge clk);
                chk("err_sticky", err_o, 1);
            end
            if (k == 4) saved_q = wq;
        end
        chk("latency_shift", lat[5] - lat[4], 3);
        diff = (saved_q.size() != wq.size()) ? 1 : 0;
        for (int i = 0; i < wq.size() && i < saved_q.size(); i++) if (wq[i] != saved_q[i]) diff++;
        chk("same_writes_l4_l7", diff, 0);

        // start held high for a whole pass, then re-issued one cycle after done
        @(negedge clk);
        wq.delete(); done_cnt = 0; mlat = 4; mbad = -1;
        start_i = 1'b1; pop_sel_i = 1'b0;
        n = 0;
        while (!done_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("held_done_seen", done_o, 1);
        start_i = 1'b0;
        @(negedge clk);
        chk("held_one_done", done_cnt, 1);
        chk("held_writes", wq.size(), POP_SIZE);
        chk("held_idle", busy_o, 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("restart_busy", busy_o, 1);
        n = 0;
        while (!done_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("restart_done_seen", done_o, 1);
        repeat (3) @(negedge clk);
        chk("restart_two_dones", done_cnt, 2);
        chk("restart_writes", wq.size(), 2 * POP_SIZE);

        // reset while issuing address 20
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!(pop_rd_en_o && pop_rd_addr_o == ADDR_W'(20)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_addr20_reached", pop_rd_addr_o, 20);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_rd_en", pop_rd_en_o, 0);
        strobes = 0;
        repeat (20) begin
            @(negedge clk);
            if (pop_rd_en_o || fit_wr_en_o || done_o || busy_o) strobes++;
        end
        chk("midrst_no_strobes", strobes, 0);
        fresh = '{2, 1'b0, 5, -1, 1'b0, 10'd0, 0};
        run_pass(fresh, "after_rst", n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
